window_stream_sequencer: RTL

//  Front-end controller for the window fetcher and its Z-stream buffers. Accepts a valid/ready pixel

---
 rtl/window_pkg.sv | 10 +
 rtl/frame_position_counter.sv | 29 ++
 rtl/window_stream_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/window_pkg.sv
// window_pkg: shared state type and window-geometry helpers for the sequencer and fetcher
package window_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, RESYNC} seq_state_e;
  function automatic int win_center_rev(input int size, input int offset);
    return (size - 1) - ((size - 1) / 2 + offset);
  endfunction
  function automatic int flush_pixels(input int w_rev, input int h_rev, input int img_w);
    return h_rev * img_w + w_rev;
  endfunction
endpackage

// File: rtl/frame_position_counter.sv
// frame_position_counter: raster col/row counter with clear, advance and end-of-frame flag
module frame_position_counter #(
  parameter int COLS = 640,
  parameter int ROWS = 480,
  parameter int CW   = 16,
  parameter int RW   = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          last_o
);
  logic col_end, row_end;
  assign col_end = col_o == CW'(COLS - 1);
  assign row_end = row_o == RW'(ROWS - 1);
  assign last_o  = col_end && row_end;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      col_o <= '0;
      row_o <= '0;
    end else if (advance_i) begin
      col_o <= col_end ? '0 : col_o + CW'(1);
      row_o <= !col_end ? row_o : row_end ? '0 : row_o + RW'(1);
    end
  end
endmodule

// File: rtl/window_stream_sequencer.sv
// window_stream_sequencer: tags the pixel stream with col/row for the window fetcher, drains
// the fetcher with flush pixels at frame end and realigns it with a one-cycle reset
module window_stream_sequencer
  import window_pkg::*;
#(
  parameter int DATA_WIDTH                  = 16,
  parameter int IMAGE_WIDTH                 = 640,
  parameter int IMAGE_HEIGHT                = 480,
  parameter int WINDOW_WIDTH                = 3,
  parameter int WINDOW_HEIGHT               = 3,
  parameter int WINDOW_WIDTH_CENTER_OFFSET  = 0,
  parameter int WINDOW_HEIGHT_CENTER_OFFSET = 0,
  parameter int IDLE_TIMEOUT                = 64,
  parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  sof_i,
  output logic                  ready_o,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [15:0]           col_o,
  output logic [15:0]           row_o,
  output logic                  valid_o,
  output logic                  fetch_rst_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  sync_err_o
);
  localparam int W_REV        = win_center_rev(WINDOW_WIDTH, WINDOW_WIDTH_CENTER_OFFSET);
  localparam int H_REV        = win_center_rev(WINDOW_HEIGHT, WINDOW_HEIGHT_CENTER_OFFSET);
  localparam int FLUSH_PIXELS = flush_pixels(W_REV, H_REV, IMAGE_WIDTH);
  localparam int FCW          = FLUSH_PIXELS > 0 ? $clog2(FLUSH_PIXELS + 1) : 1;
  localparam int ICW          = IDLE_TIMEOUT > 0 ? $clog2(IDLE_TIMEOUT + 1) : 1;

  if (IMAGE_WIDTH > 65535 || IMAGE_HEIGHT > 65535) begin : g_size_check
    $error("IMAGE_WIDTH and IMAGE_HEIGHT must fit the 16-bit position counters");
  end

  seq_state_e     state, state_n;
  logic           dirty, pend;
  logic [ICW-1:0] idle_cnt;
  logic [15:0]    col, row;
  logic [FCW-1:0] fcol;
  logic           frow, flush_unused;
  logic           pos_last, flush_last, trigger, xfer, sync_bad, emit_px, emit_flush;

  frame_position_counter #(.COLS(IMAGE_WIDTH), .ROWS(IMAGE_HEIGHT), .CW(16), .RW(16)) u_pos (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(state == RESYNC), .advance_i(emit_px || emit_flush),
    .col_o(col), .row_o(row), .last_o(pos_last)
  );

  // flush progress reuses the raster counter as a single row of FLUSH_PIXELS
  frame_position_counter #(.COLS(FLUSH_PIXELS > 0 ? FLUSH_PIXELS : 1), .ROWS(1), .CW(FCW), .RW(1)) u_flush (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(state != FLUSH), .advance_i(emit_flush),
    .col_o(fcol), .row_o(frow), .last_o(flush_last)
  );
  assign flush_unused = ^{fcol, frow};

  assign trigger     = state == IDLE && dirty &&
                       (pend || (IDLE_TIMEOUT != 0 && idle_cnt == ICW'(IDLE_TIMEOUT)));
  assign ready_o     = rst_ni && (state == ACTIVE || (state == IDLE && !trigger));
  assign xfer        = valid_i && ready_o;
  assign sync_bad    = xfer && sof_i && !(col == '0 && row == '0);
  assign emit_px     = xfer && !sync_bad;
  assign emit_flush  = state == FLUSH;
  assign fetch_rst_o = !rst_ni || state == RESYNC;
  assign busy_o      = rst_ni && state != IDLE;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = trigger ? (FLUSH_PIXELS == 0 ? RESYNC : FLUSH) : emit_px ? ACTIVE : IDLE;
      ACTIVE:  state_n = sync_bad ? RESYNC : (emit_px && pos_last) ? IDLE : ACTIVE;
      FLUSH:   state_n = flush_last ? RESYNC : FLUSH;
      RESYNC:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      dirty        <= 1'b0;
      pend         <= 1'b0;
      idle_cnt     <= '0;
      sync_err_o   <= 1'b0;
      valid_o      <= 1'b0;
      data_o       <= '0;
      col_o        <= '0;
      row_o        <= '0;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_n;
      dirty        <= state != RESYNC && (dirty || emit_px);
      pend         <= trigger ? 1'b0 : flush_i ? dirty : pend && dirty;
      idle_cnt     <= (state != IDLE || xfer) ? '0 :
                      idle_cnt + ICW'(idle_cnt != ICW'(IDLE_TIMEOUT));
      sync_err_o   <= sync_err_o || sync_bad;
      valid_o      <= emit_px || emit_flush;
      data_o       <= emit_flush ? FLUSH_VALUE : data_i;
      col_o        <= col;
      row_o        <= row;
      frame_done_o <= emit_px && pos_last;
    end
  end
endmodule
